multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 opcode  in  7  instruction[6:0], taken from the external instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completion handshake.
REQ-007 pc_en  out  1  PC load enable; equals pc_write | (branch & zero).
REQ-008 pc_write, branch, ir_write, mem_read, mem_write, iord, reg_write, pc_src, illegal  out  1 each  datapath controls.
REQ-009 result_src  out  2  writeback select: 00 ALUOut, 01 mem data, 10 PC.
REQ-010 alu_src_a  out  2  ALU A select: 00 PC, 01 reg A, 10 old PC.
REQ-011 alu_src_b  out  2  ALU B select: 00 reg B, 01 const 4, 10 immediate.
REQ-012 alu_op  out  2  ALU operation: 00 add, 01 sub, 10 R-type funct, 11 I-type funct3.
REQ-013 state  out  4  current state, for debug.

Function
REQ-014 The state SHALL be a registered 4-bit Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, ALUWB=7, EXEC_I=8, BEQ=9, JAL=10, ILLEGAL=11.
REQ-015 Every output not listed for a state SHALL be 0.
REQ-016 FETCH SHALL drive mem_read=1, iord=0, src_a=00, src_b=01, alu_op=00.
REQ-017 In FETCH, ir_write and pc_write SHALL be 1 only while mem_ready=1; the FSM SHALL hold FETCH until mem_ready=1, then go to DECODE.
REQ-018 DECODE SHALL drive src_a=10, src_b=10, alu_op=00, so the branch/jump target is latched in ALUOut.
REQ-019 DECODE next-state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BEQ; any other value -> ILLEGAL.
REQ-020 MEMADR SHALL drive src_a=01, src_b=10, alu_op=00; next state is MEMREAD if opcode=0000011, else MEMWRITE.
REQ-021 MEMREAD SHALL drive mem_read=1, iord=1 and hold until mem_ready=1, then go to MEMWB.
REQ-022 MEMWB SHALL drive reg_write=1, result_src=01, then go to FETCH.
REQ-023 MEMWRITE SHALL drive mem_write=1, iord=1 and hold until mem_ready=1, then go to FETCH.
REQ-024 EXEC_R SHALL drive src_a=01, src_b=00, alu_op=10, then go to ALUWB.
REQ-025 EXEC_I SHALL drive src_a=01, src_b=10, alu_op=11, then go to ALUWB.
REQ-026 ALUWB SHALL drive reg_write=1, result_src=00, then go to FETCH.
REQ-027 BEQ SHALL drive src_a=01, src_b=00, alu_op=01, branch=1, pc_src=1, then go to FETCH.
REQ-028 ILLEGAL SHALL drive illegal=1 for exactly one cycle, then go to FETCH; the PC has already advanced, so the instruction is skipped.
REQ-029 Unused encodings (12-15) SHALL transition to FETCH with all outputs 0.
REQ-030 Latency: load = 5 cycles, store = 4, R/I-type = 4, beq = 3, each plus mem_ready wait cycles.

Reset
REQ-031 When rst_n=0 at a rising clk edge, the state SHALL become FETCH.
REQ-032 While rst_n=0, all outputs SHALL be forced to 0 combinationally, including pc_en and state=0.
REQ-033 Reset asserted mid-access (MEMREAD/MEMWRITE) SHALL abandon the access; mem_read and mem_write drop in the same cycle.

Configuration
REQ-034 Macro JAL_EN SHALL control jump support.
REQ-035 With JAL_EN defined, opcode 1101111 in DECODE SHALL go to JAL.
REQ-036 JAL SHALL drive reg_write=1, result_src=10, pc_write=1, pc_src=1, then go to FETCH.
REQ-037 Without JAL_EN, state JAL SHALL not exist and opcode 1101111 SHALL go to ILLEGAL.

Verification
REQ-038 rst_n=0 for 2 cycles, then 1 -> outputs all 0 during reset; state=0 after; FETCH with mem_ready=0 for 3 cycles holds mem_read=1, ir_write=0.
REQ-039 opcode=0000011, mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 with result_src=01 only in MEMWB.
REQ-040 opcode=1100011 with zero=1, then with zero=0 -> pc_en=1 in BEQ for zero=1 only; pc_src=1, alu_op=01 in both runs.
REQ-041 opcode=0100011, mem_ready low 2 cycles in MEMWRITE -> mem_write=1 for 3 cycles; reg_write never 1; returns to FETCH.
REQ-042 opcode=1101111, built with and without JAL_EN -> with: state 10, reg_write=1, result_src=10; without: state 11, illegal=1 for 1 cycle.
REQ-043 rst_n=0 during MEMREAD -> mem_read=0 in the same cycle; state=0 next edge.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control -- main control FSM for a multicycle RISC-V style datapath.
//
// A Moore FSM steps each instruction through fetch, decode and one or more
// execute/memory/writeback states. It drives the datapath select, enable and
// ALU-operation controls for each state. The only inputs that act on the
// outputs directly are mem_ready, which gates ir_write/pc_write in FETCH, and
// zero, which forms pc_en.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset; also zeroes every output
//   opcode     in   7  instruction[6:0] from the external instruction register
//   zero       in   1  ALU zero flag
//   mem_ready  in   1  memory completion handshake
//   pc_en      out  1  PC load enable = pc_write | (branch & zero)
//   pc_write, branch, ir_write, mem_read, mem_write, iord, reg_write,
//   pc_src, illegal  out 1 each  datapath controls
//   result_src out  2  00 ALUOut, 01 mem data, 10 PC
//   alu_src_a  out  2  00 PC, 01 reg A, 10 old PC
//   alu_src_b  out  2  00 reg B, 01 const 4, 10 immediate
//   alu_op     out  2  00 add, 01 sub, 10 R-type funct, 11 I-type funct3
//   state      out  4  current state, for debug
//
// Build option: define JAL_EN to add the JAL state (opcode 1101111). When
// JAL_EN is undefined, that opcode is treated as illegal.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       pc_write,
  output logic       branch,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       pc_src,
  output logic       illegal,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
`ifdef JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    ALUWB    = 4'd7,
    EXEC_I   = 4'd8,
    BEQ      = 4'd9,
`ifdef JAL_EN
    JAL      = 4'd10,
`endif
    ILLEGAL  = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    state      = state_q;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Target PC (old PC + immediate) goes into ALUOut for BEQ/JAL.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXEC_R;
          OP_ITYPE:          state_d = EXEC_I;
          OP_BEQ:            state_d = BEQ;
`ifdef JAL_EN
          OP_JAL:            state_d = JAL;
`endif
          default:           state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
      end
      MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWRITE;
      end
      EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_src    = 1'b1;
      end
`ifdef JAL_EN
      JAL: begin
        reg_write  = 1'b1;
        result_src = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
      end
`endif
      ILLEGAL: begin
        // PC already advanced in FETCH, so returning skips the instruction.
        illegal = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset overrides every output in the same cycle, abandoning any access.
    if (!rst_n) begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      pc_src     = 1'b0;
      illegal    = 1'b0;
      result_src = '0;
      alu_src_a  = '0;
      alu_src_b  = '0;
      alu_op     = '0;
      state      = '0;
    end

    pc_en = pc_write | (branch & zero);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control -- directed bench for multicycle_control.
// Each instruction is expanded into a per-cycle plan (expected state plus
// the mem_ready/zero/opcode/reset values to drive). Expected controls come
// from a per-state table plus pc_en = pc_write | (branch & zero). Literal
// checks after each run pin the state sequences and the key output counts.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, pc_write, branch, ir_write, mem_read, mem_write, iord;
  logic       reg_write, pc_src, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_write(pc_write),
    .branch(branch), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .pc_src(pc_src), .illegal(illegal), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                 S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_ALUWB = 7,
                 S_EXECI = 8, S_BEQ = 9, S_JAL = 10, S_ILLEGAL = 11;

  typedef struct {
    int       st;
    bit       mr;
    bit       rst;
    bit       z;
    bit [6:0] op;
  } step_t;

  step_t       plan[$];
  logic [21:0] obs[$];
  step_t       cur;
  bit          chk_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  // Bit layout: [21]pc_en [20]pc_write [19]branch [18]ir_write [17]mem_read
  // [16]mem_write [15]iord [14]reg_write [13]pc_src [12]illegal
  // [11:10]result_src [9:8]alu_src_a [7:6]alu_src_b [5:4]alu_op [3:0]state
  function automatic logic [21:0] model(step_t s);
    logic pw, br, irw, mrd, mwr, io, rw, ps, il;
    logic [1:0] rs, sa, sb, op;
    pw = 0; br = 0; irw = 0; mrd = 0; mwr = 0; io = 0; rw = 0; ps = 0; il = 0;
    rs = 0; sa = 0; sb = 0; op = 0;
    if (s.rst) return '0;
    case (s.st)
      S_FETCH:    begin mrd = 1; sb = 2'b01; irw = s.mr; pw = s.mr; end
      S_DECODE:   begin sa = 2'b10; sb = 2'b10; end
      S_MEMADR:   begin sa = 2'b01; sb = 2'b10; end
      S_MEMREAD:  begin mrd = 1; io = 1; end
      S_MEMWB:    begin rw = 1; rs = 2'b01; end
      S_MEMWRITE: begin mwr = 1; io = 1; end
      S_EXECR:    begin sa = 2'b01; op = 2'b10; end
      S_EXECI:    begin sa = 2'b01; sb = 2'b10; op = 2'b11; end
      S_ALUWB:    begin rw = 1; end
      S_BEQ:      begin sa = 2'b01; op = 2'b01; br = 1; ps = 1; end
      S_JAL:      begin rw = 1; rs = 2'b10; pw = 1; ps = 1; end
      S_ILLEGAL:  begin il = 1; end
      default:    ;
    endcase
    return {pw | (br & s.z), pw, br, irw, mrd, mwr, io, rw, ps, il,
            rs, sa, sb, op, 4'(s.st)};
  endfunction

  function automatic logic [21:0] actual();
    return {pc_en, pc_write, branch, ir_write, mem_read, mem_write, iord,
            reg_write, pc_src, illegal, result_src, alu_src_a, alu_src_b,
            alu_op, state};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [21:0] exp_v, act_v;
      exp_v = model(cur);
      act_v = actual();
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL ctl t=%0t plan_state=%0d: got %h expected %h",
                 $time, cur.st, act_v, exp_v);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic add(input int st, input bit mr, input bit rst,
                     input bit z, input bit [6:0] op);
    step_t s;
    s.st = st; s.mr = mr; s.rst = rst; s.z = z; s.op = op;
    plan.push_back(s);
  endtask

  // Expand one instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic add_instr(input bit [6:0] op, input bit z,
                           input int fw, input int mw);
    for (int i = 0; i < fw; i++) add(S_FETCH, 0, 0, z, op);
    add(S_FETCH, 1, 0, z, op);
    add(S_DECODE, 0, 0, z, op);
    case (op)
      7'b0000011: begin
        add(S_MEMADR, 0, 0, z, op);
        for (int i = 0; i < mw; i++) add(S_MEMREAD, 0, 0, z, op);
        add(S_MEMREAD, 1, 0, z, op);
        add(S_MEMWB, 0, 0, z, op);
      end
      7'b0100011: begin
        add(S_MEMADR, 0, 0, z, op);
        for (int i = 0; i < mw; i++) add(S_MEMWRITE, 0, 0, z, op);
        add(S_MEMWRITE, 1, 0, z, op);
      end
      7'b0110011: begin add(S_EXECR, 0, 0, z, op); add(S_ALUWB, 0, 0, z, op); end
      7'b0010011: begin add(S_EXECI, 0, 0, z, op); add(S_ALUWB, 0, 0, z, op); end
      7'b1100011: add(S_BEQ, 0, 0, z, op);
`ifdef JAL_EN
      7'b1101111: add(S_JAL, 0, 0, z, op);
`endif
      default:    add(S_ILLEGAL, 0, 0, z, op);
    endcase
  endtask

  task automatic run();
    obs.delete();
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      rst_n     = !plan[i].rst;
      mem_ready = plan[i].mr;
      zero      = plan[i].z;
      opcode    = plan[i].op;
      cur       = plan[i];
      chk_en    = 1'b1;
      @(negedge clk);
      #1;
      obs.push_back(actual());
    end
    plan.delete();
  endtask

  function automatic int count_bit(input int b);
    int n = 0;
    foreach (obs[i]) n += int'(obs[i][b]);
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset for two cycles: every output zero.
    add(S_FETCH, 1, 1, 1, 7'b0000011);
    add(S_FETCH, 1, 1, 1, 7'b0000011);
    run();
    lit("rst_outputs", int'(obs[0] | obs[1]), 0);

    // Load with 3 fetch wait cycles.
    add_instr(7'b0000011, 0, 3, 0);
    run();
    lit("ld_fetch_state", int'(obs[0][3:0]), 0);
    lit("ld_fetch_hold_mrd", int'(obs[2][17]), 1);
    lit("ld_fetch_hold_irw", int'(obs[2][18]), 0);
    lit("ld_irw_count", count_bit(18), 1);
    lit("ld_seq", int'({obs[3][3:0], obs[4][3:0], obs[5][3:0], obs[6][3:0], obs[7][3:0]}),
        int'(20'h01234));
    lit("ld_regwrite_count", count_bit(14), 1);
    lit("ld_memwb_rs", int'(obs[7][11:10]), 1);

    // BEQ taken then not taken.
    add_instr(7'b1100011, 1, 0, 0);
    run();
    lit("beq_z1_state", int'(obs[2][3:0]), 9);
    lit("beq_z1_pcen", int'(obs[2][21]), 1);
    lit("beq_z1_aluop", int'(obs[2][5:4]), 1);
    add_instr(7'b1100011, 0, 0, 0);
    run();
    lit("beq_z0_pcen", int'(obs[2][21]), 0);
    lit("beq_z0_pcsrc", int'(obs[2][13]), 1);
    lit("beq_z0_aluop", int'(obs[2][5:4]), 1);

    // Store with 2 memory wait cycles.
    add_instr(7'b0100011, 0, 0, 2);
    run();
    lit("st_memwrite_cycles", count_bit(16), 3);
    lit("st_regwrite_count", count_bit(14), 0);

    // R-type and I-type.
    add_instr(7'b0110011, 0, 1, 0);
    run();
    lit("r_exec_aluop", int'(obs[3][5:4]), 2);
    lit("r_len", obs.size(), 5);
    add_instr(7'b0010011, 1, 0, 0);
    run();
    lit("i_exec_state", int'(obs[2][3:0]), 8);
    lit("i_wb_state", int'(obs[3][3:0]), 7);

    // JAL opcode.
    add_instr(7'b1101111, 0, 0, 0);
    run();
`ifdef JAL_EN
    lit("jal_state", int'(obs[2][3:0]), 10);
    lit("jal_rw", int'(obs[2][14]), 1);
    lit("jal_rs", int'(obs[2][11:10]), 2);
`else
    lit("jal_illegal_state", int'(obs[2][3:0]), 11);
    lit("jal_illegal_cycles", count_bit(12), 1);
`endif

    // Unknown opcode goes to ILLEGAL.
    add_instr(7'b1111111, 0, 0, 0);
    run();
    lit("bad_op_state", int'(obs[2][3:0]), 11);

    // Reset asserted during MEMREAD abandons the access.
    add(S_FETCH, 1, 0, 0, 7'b0000011);
    add(S_DECODE, 0, 0, 0, 7'b0000011);
    add(S_MEMADR, 0, 0, 0, 7'b0000011);
    add(S_MEMREAD, 0, 0, 0, 7'b0000011);
    add(S_MEMREAD, 0, 1, 0, 7'b0000011);
    add(S_FETCH, 0, 0, 0, 7'b0000011);
    run();
    lit("rst_mid_before_mrd", int'(obs[3][17]), 1);
    lit("rst_mid_mrd", int'(obs[4][17]), 0);
    lit("rst_mid_state_after", int'(obs[5][3:0]), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
